// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NREQ byte streams, with bursts of up to MAX_BURST characters.
// Optional feature: define UART_ARB_TAG_EN to send a TAG_BASE|grant_id character before each burst.
module uart_tx_arbiter #(
  parameter int unsigned      NREQ      = 4,
  parameter int unsigned      NCHAR     = 8,
  parameter int unsigned      MAX_BURST = 4,
  parameter logic [NCHAR-1:0] TAG_BASE  = NCHAR'(8'hF0)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*NCHAR-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [NCHAR-1:0]          tx_data,
  output logic                      tx_start,
  input  logic                      tx_ready,
  output logic                      grant_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
`ifdef UART_ARB_TAG_EN
    S_TAG,
`endif
    S_SEND,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            last_q, last_d;

  logic [IW-1:0]   sel_id;
  logic            sel_found;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   next_ptr;
  logic            end_burst;
  logic [NCHAR-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*NCHAR +: NCHAR];
  end

`ifndef UART_ARB_TAG_EN
  logic unused_tag_base;
  assign unused_tag_base = ^TAG_BASE;
`endif

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign next_ptr = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    last_d        = last_q;
    tx_start      = 1'b0;
    tx_data       = '0;
    req_ready     = '0;
    end_burst     = 1'b0;
    case (state_q)
      S_IDLE: if (|req_valid) state_d = S_ARB;
      S_ARB: begin
        if (sel_found) begin
          grant_id_d    = sel_id;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          last_d        = 1'b0;
`ifdef UART_ARB_TAG_EN
          state_d       = S_TAG;
`else
          state_d       = S_SEND;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        tx_start = 1'b1;
        tx_data  = TAG_BASE | NCHAR'(grant_id_q);
        if (tx_ready) state_d = S_WAIT;
      end
`endif
      S_SEND: begin
        tx_start = req_valid[grant_id_q];
        tx_data  = data_arr[grant_id_q];
        if (!req_valid[grant_id_q]) begin
          end_burst = 1'b1;
        end else if (tx_ready) begin
          req_ready[grant_id_q] = 1'b1;
          burst_cnt_d = burst_cnt_q + CW'(1);
          last_d      = req_last[grant_id_q];
          state_d     = S_WAIT;
        end
      end
      // Frame in flight; the burst only ends once the serializer is free again.
      S_WAIT: begin
        if (tx_ready) begin
          if (last_q || burst_cnt_q == CW'(MAX_BURST)) end_burst = 1'b1;
          else                                         state_d   = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (end_burst) begin
      ptr_d         = next_ptr;
      grant_valid_d = 1'b0;
      state_d       = (|req_valid) ? S_ARB : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      last_q        <= last_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester stream scoreboard plus burst/round-robin rule model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned NCHAR     = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned FRAME     = 11;
  localparam logic [7:0]  TAG_BASE  = 8'hF0;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } item_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_last, req_ready;
  logic [NREQ*NCHAR-1:0] req_data;
  logic [NCHAR-1:0]      tx_data;
  logic                  tx_start, tx_ready, grant_valid;
  logic [1:0]            grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .NCHAR(NCHAR), .MAX_BURST(MAX_BURST), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // Serializer model: busy for FRAME bit-times after each accepted frame; not affected by rst.
  int unsigned busy = 0;
  always @(posedge clk) begin
    if (tx_start && tx_ready) busy <= FRAME;
    else if (busy != 0)       busy <= busy - 1;
  end
  assign tx_ready = (busy == 0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  item_t drv_q [NREQ][$];
  item_t exp_q [NREQ][$];
  int unsigned wait_cnt [NREQ];
  logic [NREQ-1:0] acc_mask = '0;

  task automatic push_item(input int r, input logic [7:0] d, input logic l, input int g);
    item_t it;
    it.data = d;
    it.last = l;
    it.gap  = 8'(g);
    drv_q[r].push_back(it);
    exp_q[r].push_back(it);
  endtask

  // Requester drivers: present queue front after its gap, hold it until accepted.
  initial begin
    item_t dummy;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] && drv_q[i].size() > 0) begin
          dummy = drv_q[i].pop_front();
          wait_cnt[i] = 0;
        end
        if (drv_q[i].size() > 0 && wait_cnt[i] >= 32'(drv_q[i][0].gap)) begin
          req_valid[i] = 1'b1;
          req_data[i*NCHAR +: NCHAR] = drv_q[i][0].data;
          req_last[i]  = drv_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*NCHAR +: NCHAR] = 8'h00;
          req_last[i]  = 1'b0;
          if (drv_q[i].size() > 0) wait_cnt[i]++;
        end
      end
    end
  end

  // Reference model of the arbitration rules, observed at the falling edge.
  int           m_ptr = 0, m_id = 0, m_cnt = 0;
  bit           m_last = 0, m_tag = 0;
  logic [NREQ-1:0] prev_valid = '0;
  logic         prev_gv = 1'b0, prev_rdy = 1'b1;
  int           cyc = 0, last_rdy_rise = 0, stall_cnt = 0;
  int           grant_log[$], lat_log[$], bid_log[$], bcnt_log[$];
  logic [7:0]   tx_log[$];

  initial begin
    int e, c;
    item_t it;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        acc_mask = '0;
        m_ptr    = 0;
        prev_gv  = 1'b0;
        m_tag    = 1'b0;
      end else begin
        acc_mask = req_ready;
        if (tx_ready && !prev_rdy) last_rdy_rise = cyc;
        if (tx_start && !tx_ready) stall_cnt++;
        if (grant_valid && !prev_gv) begin
          e = -1;
          for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (e < 0 && prev_valid[c]) e = c;
          end
          check_eq("grant_id", 32'(grant_id), 32'(e));
          m_id   = int'(grant_id);
          m_cnt  = 0;
          m_last = 1'b0;
          m_tag  = TAG_ON;
          grant_log.push_back(m_id);
          lat_log.push_back(cyc - last_rdy_rise);
        end
        if (tx_start && tx_ready) begin
          check_eq("acc_gv", 32'(grant_valid), 32'(1));
          if (m_tag) begin
            check_eq("tag_char", 32'(tx_data), 32'(TAG_BASE | 8'(m_id)));
            check_eq("tag_rdy", 32'(req_ready), 32'(0));
            m_tag = 1'b0;
          end else begin
            check_eq("acc_rdy", 32'(req_ready), 32'(1) << m_id);
            check_eq("burst_room", 32'(m_cnt < MAX_BURST && !m_last), 32'(1));
            check_eq("stream_left", 32'(exp_q[m_id].size() > 0), 32'(1));
            if (exp_q[m_id].size() > 0) begin
              it = exp_q[m_id].pop_front();
              check_eq("tx_data", 32'(tx_data), 32'(it.data));
              m_last = it.last;
            end
            m_cnt++;
          end
          tx_log.push_back(tx_data);
        end else if (req_ready != '0) begin
          check_eq("rdy_no_acc", 32'(req_ready), 32'(0));
        end
        if (!grant_valid && prev_gv) begin
          check_eq("burst_end_ok", 32'(m_last || m_cnt == MAX_BURST || !prev_valid[m_id]), 32'(1));
          bid_log.push_back(m_id);
          bcnt_log.push_back(m_cnt);
          m_ptr = (m_id + 1) % NREQ;
        end
        prev_gv = grant_valid;
      end
      prev_valid = req_valid;
      prev_rdy   = tx_ready;
    end
  end

  task automatic clear_logs();
    grant_log.delete(); lat_log.delete(); bid_log.delete(); bcnt_log.delete(); tx_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gv"},  32'(grant_valid), 32'(0));
    check_eq({tag, "_gid"}, 32'(grant_id),    32'(0));
    check_eq({tag, "_st"},  32'(tx_start),    32'(0));
    check_eq({tag, "_txd"}, 32'(tx_data),     32'(0));
    check_eq({tag, "_rdy"}, 32'(req_ready),   32'(0));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int left, n;
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      left = 0;
      for (int r = 0; r < NREQ; r++) left += drv_q[r].size();
      done = (left == 0) && !grant_valid && tx_ready;
    end
    check_eq({tag, "_timeout"}, 32'(!done), 32'(0));
    n = 0;
    for (int r = 0; r < NREQ; r++) n += exp_q[r].size();
    check_eq({tag, "_exp_left"}, 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sb;
    bit hit;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst0");
    clear_logs();

    // Single requester: 41,42 with last; then ptr must start at 2.
    @(negedge clk);
    push_item(1, 8'h41, 1'b0, 0);
    push_item(1, 8'h42, 1'b1, 0);
    n = 0; hit = 1'b0;
    for (int i = 1; i <= 10 && !hit; i++) begin
      @(negedge clk);
      if (tx_start) begin hit = 1'b1; n = i; end
    end
    check_eq("s1_latency", 32'(n), 32'(3));
    wait_idle("s1", 200);
    n = TAG_ON ? 1 : 0;
    check_eq("s1_ntx", 32'(tx_log.size()), 32'(n + 2));
    check_eq("s1_tx0", 32'(tx_log[n]), 32'h41);
    check_eq("s1_tx1", 32'(tx_log[n+1]), 32'h42);
    push_item(0, 8'h10, 1'b1, 0);
    push_item(2, 8'h20, 1'b1, 0);
    wait_idle("s1b", 200);
    check_eq("s1_ptr2", 32'(grant_log[1]), 32'(2));

    // All requesters continuously valid, one-character bursts.
    do_reset();
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      push_item(r, 8'(8'h60 + r), 1'b1, 0);
      push_item(r, 8'(8'h70 + r), 1'b1, 0);
    end
    wait_idle("s2", 1000);
    for (int k = 0; k < 5; k++) check_eq("s2_order", 32'(grant_log[k]), 32'(k % NREQ));

    // Long stream from req 2 is cut into MAX_BURST bursts around req 3.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 10; k++) push_item(2, 8'(8'h80 + k), 1'b0, 0);
    push_item(3, 8'h90, 1'b0, 0);
    push_item(3, 8'h91, 1'b1, 0);
    wait_idle("s3", 2000);
    check_eq("s3_nburst", 32'(bid_log.size()), 32'(4));
    check_eq("s3_b0", {16'(bid_log[0]), 16'(bcnt_log[0])}, {16'd2, 16'd4});
    check_eq("s3_b1", {16'(bid_log[1]), 16'(bcnt_log[1])}, {16'd3, 16'd2});
    check_eq("s3_b2", {16'(bid_log[2]), 16'(bcnt_log[2])}, {16'd2, 16'd4});
    check_eq("s3_b3", {16'(bid_log[3]), 16'(bcnt_log[3])}, {16'd2, 16'd2});

    // Req 0 goes quiet mid-burst while req 3 waits.
    do_reset();
    @(negedge clk);
    push_item(0, 8'hA0, 1'b0, 0);
    push_item(0, 8'hA1, 1'b0, 40);
    push_item(0, 8'hA2, 1'b1, 0);
    push_item(3, 8'h30, 1'b1, 0);
    wait_idle("s4", 1000);
    check_eq("s4_ngrant", 32'(grant_log.size()), 32'(3));
    check_eq("s4_g1", 32'(grant_log[1]), 32'(3));
    check_eq("s4_lat", 32'(lat_log[1] <= 3), 32'(1));
    check_eq("s4_b0cnt", 32'(bcnt_log[0]), 32'(1));

    // Reset while waiting on the serializer.
    do_reset();
    @(negedge clk);
    push_item(1, 8'h51, 1'b0, 0);
    push_item(1, 8'h52, 1'b1, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (exp_q[1].size() == 1) && !tx_ready;
    end
    check_eq("s5_reach_wait", 32'(hit), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    sb = stall_cnt;
    @(negedge clk);
    check_reset_outputs("s5");
    wait_idle("s5", 500);
    check_eq("s5_gated", 32'(stall_cnt > sb), 32'(1));
    n = TAG_ON ? 1 : 0;
    check_eq("s5_ntx", 32'(tx_log.size()), 32'(n + 1));
    check_eq("s5_tx", 32'(tx_log[n]), 32'h52);

    // Single character from req 3 (tag precedes it when enabled).
    do_reset();
    @(negedge clk);
    push_item(3, 8'h55, 1'b1, 0);
    wait_idle("s6", 200);
`ifdef UART_ARB_TAG_EN
    check_eq("s6_ntx", 32'(tx_log.size()), 32'(2));
    check_eq("s6_tag", 32'(tx_log[0]), 32'hF3);
    check_eq("s6_chr", 32'(tx_log[1]), 32'h55);
`else
    check_eq("s6_ntx", 32'(tx_log.size()), 32'(1));
    check_eq("s6_chr", 32'(tx_log[0]), 32'h55);
`endif

    // Random long run.
    do_reset();
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      for (int k = 0; k < 40; k++) begin
        push_item(r, 8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 25)) : 0);
      end
    end
    wait_idle("rand", 30000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
